job_rr_scheduler: RTL and testbench

//  Shares one timed engine (start pulse in; busy/done pulse out) between N requesters.

---
 rtl/job_rr_scheduler_pkg.sv | 16 +
 rtl/job_rr_scheduler_if.sv | 29 ++
 rtl/job_rr_scheduler_rr_pick.sv | 44 ++++
 rtl/job_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_job_rr_scheduler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/job_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin engine scheduler.
package job_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  // Width of a requester index; a single requester still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/job_rr_scheduler_if.sv
// Client/engine-facing bundle of the scheduler.
// The master side is the scheduler; the slave side is the clients plus the engine.
interface job_rr_scheduler_if #(
  parameter int N_REQ = 4
);
  import job_rr_scheduler_pkg::*;

  localparam int IDXW = idx_width(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] gnt_o;
  logic [N_REQ-1:0] done_o;
  logic             err_o;
  logic [IDXW-1:0]  owner_o;
  logic             eng_start_o;
  logic             eng_busy_i;
  logic             eng_done_i;

  modport master (
    input  req_i, eng_busy_i, eng_done_i,
    output gnt_o, done_o, err_o, owner_o, eng_start_o
  );

  modport slave (
    output req_i, eng_busy_i, eng_done_i,
    input  gnt_o, done_o, err_o, owner_o, eng_start_o
  );

endinterface

// File: rtl/job_rr_scheduler_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// The request vector is doubled and the lower copy masked below ptr, so a plain
// lowest-bit priority scan yields the round-robin winner.
module rr_pick
  import job_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDXW  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic             valid_o,
  output logic [IDXW-1:0]  idx_o
);

  logic [2*N_REQ-1:0] dbl;
  logic               found;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * N_REQ; gi++) begin : g_mask
      if (gi < N_REQ) begin : g_lo
        assign dbl[gi] = req_i[gi] & (IDXW'(gi) >= ptr_i);
      end else begin : g_hi
        assign dbl[gi] = req_i[gi-N_REQ];
      end
    end
  endgenerate

  assign valid_o = |req_i;

  // Lowest set bit of the doubled vector, folded back into a requester index.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx_o = (i >= N_REQ) ? IDXW'(i - N_REQ) : IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/job_rr_scheduler.sv
// Shares one timed engine among N_REQ requesters in round-robin order, forwards
// the engine's done pulse to the owner, and aborts jobs that exceed the watchdog.
module job_rr_scheduler
  import job_rr_scheduler_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  job_rr_scheduler_if.master bus
);

  localparam int IDXW = idx_width(N_REQ);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_REQ - 1);

  generate
    if (N_REQ < 1) begin : g_bad_nreq
      $error("job_rr_scheduler: N_REQ must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
      $error("job_rr_scheduler: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  sched_state_e     state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_flag_q, err_flag_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic             pick_valid;
  logic [IDXW-1:0]  pick_idx;

  // Engine busy is informational only; kept visible so the bundle stays complete.
  logic unused_busy;
  assign unused_busy = bus.eng_busy_i;

  rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
    .req_i  (bus.req_i),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  function automatic logic [N_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // Next state plus the outputs that belong to the state being entered, so the
  // registered outputs line up exactly with the state they describe.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    err_flag_d = err_flag_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    start_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = S_START;
          start_d = 1'b1;
          gnt_d   = onehot(pick_idx);
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
        gnt_d   = onehot(owner_q);
      end
      S_WAIT: begin
        gnt_d = onehot(owner_q);
        if (bus.eng_done_i) begin
          // A done arriving on the timeout cycle still counts as success.
          state_d    = S_DONE;
          err_flag_d = 1'b0;
          done_d     = onehot(owner_q);
        end else if (timer_q == TMO_LAST) begin
          state_d    = S_DONE;
          err_flag_d = 1'b1;
          err_d      = 1'b1;
          done_d     = onehot(owner_q);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDXW'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State, bookkeeping and output registers; reset clears outputs immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      timer_q    <= '0;
      err_flag_q <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      err_flag_q <= err_flag_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.owner_o     = owner_q;
  assign bus.eng_start_o = start_q;

endmodule

// File: tb/tb_job_rr_scheduler.sv
// Directed bench for job_rr_scheduler with a 5-cycle engine model and an
// owner scoreboard filled when requests are driven, drained on done_o.
module tb_job_rr_scheduler;
  import job_rr_scheduler_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  job_rr_scheduler_if #(.N_REQ(4)) bus ();

  job_rr_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Engine model: busy for 5 cycles after a start, then a one-cycle done.
  logic eng_en    = 1'b1;
  logic spur_done = 1'b0;
  int   eng_cnt;
  logic eng_busy_m, eng_done_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt    <= 0;
      eng_busy_m <= 1'b0;
      eng_done_m <= 1'b0;
    end else begin
      eng_done_m <= 1'b0;
      if (bus.eng_start_o) begin
        eng_cnt    <= 5;
        eng_busy_m <= 1'b1;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_busy_m <= 1'b0;
          eng_done_m <= eng_en;
        end
      end
    end
  end

  assign bus.eng_busy_i = eng_busy_m;
  assign bus.eng_done_i = eng_done_m | spur_done;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " gnt"},   32'(bus.gnt_o), 32'd0);
    chk({tag, " done"},  32'(bus.done_o), 32'd0);
    chk({tag, " err"},   32'(bus.err_o), 32'd0);
    chk({tag, " start"}, 32'(bus.eng_start_o), 32'd0);
  endtask

  // Compare the current done cycle against the oldest expected owner.
  task automatic done_now(input string tag, input bit exp_err);
    int o;
    chk({tag, " sb pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      o = exp_q.pop_front();
      chk({tag, " done_o"},  32'(bus.done_o), 32'(1) << o);
      chk({tag, " gnt_o"},   32'(bus.gnt_o), 32'(1) << o);
      chk({tag, " err_o"},   32'(bus.err_o), 32'(exp_err));
      chk({tag, " owner_o"}, 32'(bus.owner_o), 32'(o));
    end
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.eng_start_o) seen = 1'b1;
    end
    chk({tag, " start seen"}, 32'(seen), 32'd1);
    if (seen && exp_q.size() != 0)
      chk({tag, " start gnt"}, 32'(bus.gnt_o), 32'(1) << exp_q[0]);
  endtask

  task automatic wait_done(input string tag, input bit exp_err);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o != 4'b0000) seen = 1'b1;
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    if (seen) done_now(tag, exp_err);
  endtask

  initial begin
    bus.req_i = 4'b0000;
    // Reset state
    repeat (3) step();
    chk_idle_outputs("reset");
    chk("reset owner", 32'(bus.owner_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester: exact latency
    bus.req_i = 4'b0001;
    exp_q.push_back(0);
    step();
    chk("t1 c1 gnt",   32'(bus.gnt_o), 32'h1);
    chk("t1 c1 start", 32'(bus.eng_start_o), 32'd1);
    step();
    chk("t1 c2 start low", 32'(bus.eng_start_o), 32'd0);
    repeat (5) step();
    chk("t1 c7 no done yet", 32'(bus.done_o), 32'd0);
    step();
    done_now("t1 c8", 1'b0);
    bus.req_i = 4'b0000;
    step();
    chk_idle_outputs("t1 idle");

    // Fresh pointer, all requesting: 0,1,2,3,0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.req_i = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("t2 job%0d", k));
      wait_done($sformatf("t2 job%0d", k), 1'b0);
    end
    bus.req_i = 4'b0000;
    step();

    // Drive ptr to 3, then wrap 3 -> 0, then confirm ptr landed on 1
    bus.req_i = 4'b0100;
    exp_q.push_back(2);
    wait_start("t3 setup");
    wait_done("t3 setup", 1'b0);
    bus.req_i = 4'b0000;
    step();
    bus.req_i = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 2; k++) begin
      wait_start($sformatf("t3 wrap%0d", k));
      wait_done($sformatf("t3 wrap%0d", k), 1'b0);
    end
    bus.req_i = 4'b0000;
    step();
    bus.req_i = 4'b1111;
    exp_q.push_back(1);
    wait_start("t3 ptr1");
    wait_done("t3 ptr1", 1'b0);
    bus.req_i = 4'b0000;
    step();

    // Hung engine: timeout fires 16 cycles after entering WAIT
    eng_en = 1'b0;
    bus.req_i = 4'b0100;
    exp_q.push_back(2);
    step();
    chk("t4 c1 start", 32'(bus.eng_start_o), 32'd1);
    repeat (16) step();
    chk("t4 c17 no done yet", 32'(bus.done_o), 32'd0);
    step();
    done_now("t4 c18 timeout", 1'b1);
    bus.req_i = 4'b0000;
    step();
    chk_idle_outputs("t4 back idle");
    eng_en = 1'b1;
    step();

    // Request dropped mid-job, then a spurious engine done while idle
    bus.req_i = 4'b0001;
    exp_q.push_back(0);
    step();
    chk("t6 c1 gnt", 32'(bus.gnt_o), 32'h1);
    step();
    bus.req_i = 4'b0000;
    repeat (6) step();
    done_now("t6 c8 dropped req", 1'b0);
    step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk_idle_outputs("t6 spurious a");
    step();
    chk_idle_outputs("t6 spurious b");

    // Asynchronous reset during WAIT, then a fresh grant
    bus.req_i = 4'b0100;
    step();
    chk("t5 c1 gnt", 32'(bus.gnt_o), 32'h4);
    repeat (2) step();
    chk("t5 c3 gnt", 32'(bus.gnt_o), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("t5 async");
    chk("t5 async owner", 32'(bus.owner_o), 32'd0);
    bus.req_i = 4'b0010;
    step();
    rst_n = 1'b1;
    exp_q.push_back(1);
    step();
    chk("t5 c1 gnt",   32'(bus.gnt_o), 32'h2);
    chk("t5 c1 start", 32'(bus.eng_start_o), 32'd1);
    wait_done("t5 after reset", 1'b0);
    bus.req_i = 4'b0000;
    step();

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL global timeout: bench did not reach its summary");
    $fatal(1, "global timeout");
  end

endmodule
